neo_spike_detector: RTL and testbench

//   Stage downstream of the NEO calculator. Starts on the calculator's one-cycle ready pulse.

---
 rtl/neo_spike_detector.sv | 124 ++++++++++++
 tb/tb_neo_spike_detector.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/neo_spike_detector.sv
// Adaptive-threshold spike detector over the M-entry NEO buffer (two read passes); optional NEO_MANUAL_THR_EN bypass.
// Latency: done 2M+2 cycles after start (M+1 when manual threshold used); events 1 cycle after compare.
// Backpressure: none; start is ignored while busy, events are fire-and-forget strobes.
module neo_spike_detector #(
    parameter int N       = 16,
    parameter int M       = 32,
    parameter int K       = 8,
    parameter int REFRACT = 3
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    start,
`ifdef NEO_MANUAL_THR_EN
    input  logic                    manual_sel,
    input  logic signed [N-1:0]     manual_thr,
`endif
    input  logic signed [N-1:0]     rdata,
    output logic [$clog2(M)-1:0]    raddr,
    output logic                    busy,
    output logic signed [N-1:0]     threshold,
    output logic                    spike_valid,
    output logic [$clog2(M)-1:0]    spike_addr,
    output logic signed [N-1:0]     spike_energy,
    output logic [$clog2(M):0]      spike_count,
    output logic                    done
);

    localparam int AW = $clog2(M);
    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam int PW = N + 8;
    localparam logic [PW-1:0] SAT = {{9{1'b0}}, {(N-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, SUM, CALC, DETECT, DONE} state_t;

    state_t           state;
    logic [N+AW-1:0]  acc;
    logic [RW-1:0]    rcnt;
    logic [N-1:0]     clip;
    logic [N-1:0]     mean;
    logic [PW-1:0]    prod;
    logic             last;
    logic             hit;

    // Negative psi is noise-only energy; clipping keeps the mean non-negative.
    assign clip = rdata[N-1] ? '0 : $unsigned(rdata);
    assign mean = acc[N+AW-1:AW];
    assign prod = PW'(mean) * PW'(K);
    assign last = (raddr == AW'(M - 1));
    assign hit  = (rdata > threshold) && (rcnt == '0);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            rcnt         <= '0;
            raddr        <= '0;
            busy         <= 1'b0;
            threshold    <= '0;
            spike_valid  <= 1'b0;
            spike_addr   <= '0;
            spike_energy <= '0;
            spike_count  <= '0;
            done         <= 1'b0;
        end else begin
            spike_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    raddr <= '0;
                    if (start) begin
                        busy        <= 1'b1;
                        spike_count <= '0;
                        acc         <= '0;
`ifdef NEO_MANUAL_THR_EN
                        if (manual_sel) begin
                            threshold <= manual_thr;
                            rcnt      <= '0;
                            state     <= DETECT;
                        end else begin
                            state <= SUM;
                        end
`else
                        state <= SUM;
`endif
                    end
                end
                SUM: begin
                    acc   <= acc + {{AW{1'b0}}, clip};
                    raddr <= raddr + 1'b1;
                    if (last)
                        state <= CALC;
                end
                CALC: begin
                    threshold <= (prod > SAT) ? SAT[N-1:0] : prod[N-1:0];
                    rcnt      <= '0;
                    state     <= DETECT;
                end
                DETECT: begin
                    if (hit) begin
                        spike_valid  <= 1'b1;
                        spike_addr   <= raddr;
                        spike_energy <= rdata;
                        spike_count  <= spike_count + 1'b1;
                        rcnt         <= RW'(REFRACT);
                    end else if (rcnt != '0) begin
                        rcnt <= rcnt - 1'b1;
                    end
                    // raddr wraps back to 0 here, so IDLE starts from a clean address.
                    raddr <= raddr + 1'b1;
                    if (last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neo_spike_detector.sv
// Directed bench for neo_spike_detector: async-read psi buffer model, hand-computed thresholds and events.
module tb_neo_spike_detector;

    localparam int N = 16;
    localparam int M = 32;
    localparam int K = 4;
    localparam int REFRACT = 3;
    localparam int AW = $clog2(M);

    logic                 Clk;
    logic                 reset;
    logic                 start;
    logic signed [N-1:0]  rdata;
    logic [AW-1:0]        raddr;
    logic                 busy;
    logic signed [N-1:0]  threshold;
    logic                 spike_valid;
    logic [AW-1:0]        spike_addr;
    logic signed [N-1:0]  spike_energy;
    logic [AW:0]          spike_count;
    logic                 done;
`ifdef NEO_MANUAL_THR_EN
    logic                 manual_sel;
    logic signed [N-1:0]  manual_thr;
`endif

    logic signed [N-1:0]  mem [M];
    assign rdata = mem[raddr];

    int n_chk  = 0;
    int n_fail = 0;

    neo_spike_detector #(.N(N), .M(M), .K(K), .REFRACT(REFRACT)) dut (
        .Clk          (Clk),
        .reset        (reset),
        .start        (start),
`ifdef NEO_MANUAL_THR_EN
        .manual_sel   (manual_sel),
        .manual_thr   (manual_thr),
`endif
        .rdata        (rdata),
        .raddr        (raddr),
        .busy         (busy),
        .threshold    (threshold),
        .spike_valid  (spike_valid),
        .spike_addr   (spike_addr),
        .spike_energy (spike_energy),
        .spike_count  (spike_count),
        .done         (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < M; i++) mem[i] = N'(v);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".raddr"},  int'(raddr), 0);
        chk({nm, ".busy"},   int'(busy), 0);
        chk({nm, ".thr"},    int'(threshold), 0);
        chk({nm, ".sv"},     int'(spike_valid), 0);
        chk({nm, ".saddr"},  int'(spike_addr), 0);
        chk({nm, ".sen"},    int'(spike_energy), 0);
        chk({nm, ".scount"}, int'(spike_count), 0);
        chk({nm, ".done"},   int'(done), 0);
    endtask

    // Pulses start, collects events until done, then checks results. exp_lat counts
    // clock cycles from the start edge to the cycle in which done is high.
    task automatic run(input string nm, input int exp_thr, input int exp_n,
                       input int a0, input int e0, input int a1, input int e1,
                       input int exp_lat, input int repulse_at);
        int ev_a[$];
        int ev_e[$];
        int cyc;
        int seen;
        int extra;
        int ea[2];
        int ee[2];
        ea[0] = a0; ee[0] = e0; ea[1] = a1; ee[1] = e1;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        cyc  = 1;
        seen = 0;
        chk({nm, ".busy_on"}, int'(busy), 1);
        while (!seen && cyc < 200) begin
            if (spike_valid) begin
                ev_a.push_back(int'(spike_addr));
                ev_e.push_back(int'(spike_energy));
            end
            if (done) begin
                seen = 1;
            end else begin
                @(negedge Clk);
                cyc++;
                start = (cyc == repulse_at) ? 1'b1 : 1'b0;
            end
        end
        start = 1'b0;
        chk({nm, ".done_seen"}, seen, 1);
        chk({nm, ".latency"}, cyc, exp_lat);
        chk({nm, ".thr"}, int'(threshold), exp_thr);
        chk({nm, ".nevents"}, ev_a.size(), exp_n);
        chk({nm, ".scount"}, int'(spike_count), exp_n);
        for (int i = 0; i < exp_n && i < 2; i++) begin
            if (i < ev_a.size()) begin
                chk($sformatf("%s.ev%0d_addr", nm, i), ev_a[i], ea[i]);
                chk($sformatf("%s.ev%0d_energy", nm, i), ev_e[i], ee[i]);
            end
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (done) extra++;
            if (i == 0) chk({nm, ".busy_off"}, int'(busy), 0);
        end
        chk({nm, ".single_done"}, extra, 0);
        chk({nm, ".thr_held"}, int'(threshold), exp_thr);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
`ifdef NEO_MANUAL_THR_EN
        manual_sel = 1'b0;
        manual_thr = '0;
`endif
        fill(0);
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        chk_zero("reset");

        fill(0);
        run("t1_zero", 0, 0, -1, -1, -1, -1, 2*M+2, -1);

        fill(10); mem[5] = 16'sd1000;
        run("t2_single", 160, 1, 5, 1000, -1, -1, 2*M+2, -1);

        fill(10); mem[5] = 16'sd1000; mem[6] = 16'sd1000; mem[7] = 16'sd1000; mem[9] = 16'sd1000;
        run("t3_refract", 532, 2, 5, 1000, 9, 1000, 2*M+2, -1);

        fill(-500); mem[0] = 16'sd100;
        run("t4_negclip", 12, 1, 0, 100, -1, -1, 2*M+2, -1);

        fill(32767);
        run("t5_sat", 32767, 0, -1, -1, -1, -1, 2*M+2, -1);

        fill(10); mem[5] = 16'sd1000; mem[6] = 16'sd1000; mem[7] = 16'sd1000; mem[9] = 16'sd1000;
        run("t6_repulse", 532, 2, 5, 1000, 9, 1000, 2*M+2, M+10);

        // Reset in the middle of SUM clears everything on the next cycle.
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (10) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        chk_zero("t6_rst");

        // Start coincident with reset is dropped.
        reset = 1'b1;
        start = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge Clk);
        chk("t6_rst_start.busy", int'(busy), 0);

        fill(10); mem[5] = 16'sd1000;
        run("t6_clean", 160, 1, 5, 1000, -1, -1, 2*M+2, -1);

`ifdef NEO_MANUAL_THR_EN
        fill(10); mem[5] = 16'sd1000; mem[6] = 16'sd1000; mem[7] = 16'sd1000; mem[9] = 16'sd1000;
        manual_sel = 1'b1;
        manual_thr = 16'sd500;
        run("t7_manual", 500, 2, 5, 1000, 9, 1000, M+1, -1);
        manual_sel = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
